// File: rtl/video_timing_m_if.sv
// Raster timing bundle between the pixel-clock timing generator
// and its consumers: enable in, sync/position/strobe outputs back.
interface video_timing_m_if #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int FRAME_WIDTH = 8
);
  logic                   en;
  logic                   hsync;
  logic                   vsync;
  logic                   visible;
  logic [X_WIDTH-1:0]     hcount;
  logic [Y_WIDTH-1:0]     vcount;
  logic [X_WIDTH-1:0]     x;
  logic [Y_WIDTH-1:0]     y;
  logic                   line_start;
  logic                   frame_start;
  logic                   vblank_start;
  logic [FRAME_WIDTH-1:0] frame_count;

  modport master (
    input  en,
    output hsync, vsync, visible,
    output hcount, vcount, x, y,
    output line_start, frame_start,
    output vblank_start, frame_count
  );

  modport slave (
    output en,
    input  hsync, vsync, visible,
    input  hcount, vcount, x, y,
    input  line_start, frame_start,
    input  vblank_start, frame_count
  );
endinterface

// File: rtl/video_timing_m.sv
// Mode-configurable raster timing generator (h/v counters + one
// registered decode stage). Ports: clk_12_5875, rst (async high),
// vid (master): en in; hsync, vsync, visible, hcount, vcount, x, y,
// line_start, frame_start, vblank_start, frame_count out.
module video_timing_m #(
  parameter int H_VISIBLE    = 320,
  parameter int H_FRONT      = 8,
  parameter int H_SYNC       = 48,
  parameter int H_BACK       = 24,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int H_SCALE_LOG2 = 0,
  parameter int V_SCALE_LOG2 = 0,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10,
  parameter int FRAME_WIDTH  = 8
) (
  input logic              clk_12_5875,
  input logic              rst,
  video_timing_m_if.master vid
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam logic HS_IDLE = ~HSYNC_POL;
  localparam logic VS_IDLE = ~VSYNC_POL;

  logic [X_WIDTH-1:0]     h;
  logic [Y_WIDTH-1:0]     v;
  logic [FRAME_WIDTH-1:0] frames;

  int unsigned hn;
  int unsigned vn;
  logic        h_last;
  logic        v_last;
  logic        vis_d;
  logic        hs_d;
  logic        vs_d;

  assign hn     = 32'(h);
  assign vn     = 32'(v);
  assign h_last = (hn == H_TOTAL - 1);
  assign v_last = (vn == V_TOTAL - 1);
  assign vis_d  = (hn < H_VISIBLE) && (vn < V_VISIBLE);
  assign hs_d   = (hn >= HS_BEG) && (hn < HS_END);
  assign vs_d   = (vn >= VS_BEG) && (vn < VS_END);

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      h      <= '0;
      v      <= '0;
      frames <= '0;
    end else if (vid.en) begin
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v      <= '0;
          frames <= frames + FRAME_WIDTH'(1);
        end else begin
          v <= v + Y_WIDTH'(1);
        end
      end else begin
        h <= h + X_WIDTH'(1);
      end
    end
  end

  // Output stage trails the counters by one cycle; strobes are
  // dropped while frozen so a paused position never re-fires them.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      vid.hcount       <= '0;
      vid.vcount       <= '0;
      vid.x            <= '0;
      vid.y            <= '0;
      vid.visible      <= 1'b0;
      vid.hsync        <= HS_IDLE;
      vid.vsync        <= VS_IDLE;
      vid.line_start   <= 1'b0;
      vid.frame_start  <= 1'b0;
      vid.vblank_start <= 1'b0;
      vid.frame_count  <= '0;
    end else if (vid.en) begin
      vid.hcount       <= h;
      vid.vcount       <= v;
      vid.x            <= vis_d ? (h >> H_SCALE_LOG2) : '0;
      vid.y            <= vis_d ? (v >> V_SCALE_LOG2) : '0;
      vid.visible      <= vis_d;
      vid.hsync        <= hs_d ^ HS_IDLE;
      vid.vsync        <= vs_d ^ VS_IDLE;
      vid.line_start   <= (hn == 0);
      vid.frame_start  <= (hn == 0) && (vn == 0);
      vid.vblank_start <= (hn == 0) && (vn == V_VISIBLE);
      vid.frame_count  <= frames;
    end else begin
      vid.line_start   <= 1'b0;
      vid.frame_start  <= 1'b0;
      vid.vblank_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_m.sv
// Directed bench for video_timing_m: default mode, a small scaled
// mode with positive sync, and the 640-wide positive-sync mode.
module tb_video_timing_m;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  video_timing_m_if if0 ();
  video_timing_m_if #(
    .X_WIDTH(6), .Y_WIDTH(6), .FRAME_WIDTH(2)
  ) if1 ();
  video_timing_m_if if2 ();

  video_timing_m u0 (
    .clk_12_5875(clk), .rst(rst), .vid(if0)
  );

  video_timing_m #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(3), .V_BACK(5),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .H_SCALE_LOG2(1), .V_SCALE_LOG2(1),
    .X_WIDTH(6), .Y_WIDTH(6), .FRAME_WIDTH(2)
  ) u1 (
    .clk_12_5875(clk), .rst(rst), .vid(if1)
  );

  video_timing_m #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u2 (
    .clk_12_5875(clk), .rst(rst), .vid(if2)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hc_bad, hs_cnt, hs_first, hs_last, vis_cnt, ls_cnt, frz_bad;
  int b_pos, b_vis, b_sync, b_xy, b_stb, b_fc;
  int vs_cnt, fs_second, vb_tick, x39, x40, y29, fc3, fc4;

  initial begin
    rst = 1'b1;
    if0.en = 1'b1;
    if1.en = 1'b0;
    if2.en = 1'b0;
    repeat (3) tick();

    chk("rst_hcount", if0.hcount, 0);
    chk("rst_visible", if0.visible, 0);
    chk("rst_hsync_neg", if0.hsync, 1);
    chk("rst_vsync_neg", if0.vsync, 1);
    chk("rst_line_start", if0.line_start, 0);
    chk("rst_frame_count", if0.frame_count, 0);
    chk("rst_hsync_pos", if1.hsync, 0);
    chk("rst_vsync_pos", if1.vsync, 0);

    #2 rst = 1'b0;
    tick();
    chk("first_hcount", if0.hcount, 0);
    chk("first_vcount", if0.vcount, 0);
    chk("first_visible", if0.visible, 1);
    chk("first_line_start", if0.line_start, 1);
    chk("first_frame_start", if0.frame_start, 1);
    chk("first_hsync", if0.hsync, 1);
    chk("first_vsync", if0.vsync, 1);
    chk("first_frame_count", if0.frame_count, 0);

    hc_bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    vis_cnt = 0; ls_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) tick();
      if (int'(if0.hcount) != k) hc_bad++;
      if (if0.hsync == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      if (if0.visible) vis_cnt++;
      if (if0.visible != (k < 320)) hc_bad++;
      if (if0.line_start) ls_cnt++;
    end
    chk("line_hcount_seq", hc_bad, 0);
    chk("line_hsync_width", hs_cnt, 48);
    chk("line_hsync_first", hs_first, 328);
    chk("line_hsync_last", hs_last, 375);
    chk("line_visible_cnt", vis_cnt, 320);
    chk("line_ls_cnt", ls_cnt, 1);
    tick();
    chk("line2_hcount", if0.hcount, 0);
    chk("line2_vcount", if0.vcount, 1);
    chk("line2_line_start", if0.line_start, 1);
    chk("line2_frame_start", if0.frame_start, 0);

    repeat (100) tick();
    chk("pre_freeze_hcount", if0.hcount, 100);
    if0.en = 1'b0;
    frz_bad = 0;
    repeat (10) begin
      tick();
      if (if0.hcount != 10'd100 || if0.vcount != 10'd1) frz_bad++;
      if (!if0.visible || if0.x != 10'd100) frz_bad++;
      if (if0.line_start || if0.frame_start) frz_bad++;
    end
    chk("freeze_mid_hold", frz_bad, 0);
    if0.en = 1'b1;
    tick();
    chk("resume_hcount", if0.hcount, 101);
    repeat (298) tick();
    chk("end_line_hcount", if0.hcount, 399);
    tick();
    chk("wrap_line_start", if0.line_start, 1);
    chk("wrap_vcount", if0.vcount, 2);
    if0.en = 1'b0;
    frz_bad = 0;
    repeat (10) begin
      tick();
      if (if0.hcount != 10'd0 || if0.vcount != 10'd2) frz_bad++;
      if (if0.line_start || if0.frame_start) frz_bad++;
      if (if0.vblank_start) frz_bad++;
    end
    chk("freeze_h0_nostrobe", frz_bad, 0);
    if0.en = 1'b1;
    tick();
    chk("resume0_hcount", if0.hcount, 1);
    chk("resume0_line_start", if0.line_start, 0);

    repeat (49) tick();
    chk("pre_rst_hcount", if0.hcount, 50);
    rst = 1'b1;
    if0.en = 1'b0;
    #1;
    chk("async_rst_hcount", if0.hcount, 0);
    chk("async_rst_vcount", if0.vcount, 0);
    chk("async_rst_visible", if0.visible, 0);
    chk("async_rst_hsync", if0.hsync, 1);
    tick();
    chk("rst_beats_en_hcount", if0.hcount, 0);
    if0.en = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("post_rst_frame_start", if0.frame_start, 1);
    chk("post_rst_visible", if0.visible, 1);
    tick();
    chk("post_rst_hcount", if0.hcount, 1);

    chk("hold_en0_hsync", if1.hsync, 0);
    if1.en = 1'b1;
    b_pos = 0; b_vis = 0; b_sync = 0; b_xy = 0;
    b_stb = 0; b_fc = 0; vs_cnt = 0;
    fs_second = -1; vb_tick = -1;
    x39 = -1; x40 = -1; y29 = -1; fc3 = -1; fc4 = -1;
    for (int t = 0; t <= 4 * 2240; t++) begin
      int h, v, f, xe, ye;
      logic vis, hs, vs;
      tick();
      h = t % 56;
      v = (t / 56) % 40;
      f = (t / 2240) % 4;
      vis = (h < 40) && (v < 30);
      hs = (h >= 44) && (h < 52);
      vs = (v >= 32) && (v < 35);
      xe = vis ? h / 2 : 0;
      ye = vis ? v / 2 : 0;
      if (int'(if1.hcount) != h || int'(if1.vcount) != v) b_pos++;
      if (if1.visible != vis) b_vis++;
      if (if1.hsync != hs || if1.vsync != vs) b_sync++;
      if (int'(if1.x) != xe || int'(if1.y) != ye) b_xy++;
      if (if1.line_start != (h == 0)) b_stb++;
      if (if1.frame_start != (h == 0 && v == 0)) b_stb++;
      if (if1.vblank_start != (h == 0 && v == 30)) b_stb++;
      if (int'(if1.frame_count) != f) b_fc++;
      if (t < 2240 && if1.vsync) vs_cnt++;
      if (t > 0 && if1.frame_start && fs_second < 0) fs_second = t;
      if (if1.vblank_start && vb_tick < 0) vb_tick = t;
      if (t == 39) x39 = int'(if1.x);
      if (t == 40) x40 = int'(if1.x);
      if (t == 29 * 56) y29 = int'(if1.y);
      if (t == 3 * 2240) fc3 = int'(if1.frame_count);
      if (t == 4 * 2240) fc4 = int'(if1.frame_count);
    end
    chk("s_position", b_pos, 0);
    chk("s_visible", b_vis, 0);
    chk("s_sync", b_sync, 0);
    chk("s_xy", b_xy, 0);
    chk("s_strobes", b_stb, 0);
    chk("s_frame_count", b_fc, 0);
    chk("s_vsync_cycles", vs_cnt, 3 * 56);
    chk("s_frame_period", fs_second, 2240);
    chk("s_vblank_tick", vb_tick, 30 * 56);
    chk("s_x_h39", x39, 19);
    chk("s_x_h40", x40, 0);
    chk("s_y_line29", y29, 14);
    chk("s_fc_third", fc3, 3);
    chk("s_fc_wrap", fc4, 0);

    if2.en = 1'b1;
    hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (if2.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      if (if2.line_start) ls_cnt++;
    end
    chk("w_hsync_width", hs_cnt, 96);
    chk("w_hsync_first", hs_first, 656);
    chk("w_hsync_last", hs_last, 751);
    chk("w_ls_cnt", ls_cnt, 1);
    chk("w_vsync_idle", if2.vsync, 0);
    tick();
    chk("w_line2_hcount", if2.hcount, 0);
    chk("w_line2_vcount", if2.vcount, 1);
    chk("w_line2_ls", if2.line_start, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_m.md
# video_timing_m

Parametrised raster timing generator for the GPU pixel clock domain: it produces the horizontal and vertical counters, sync pulses, visible-region flag, logical (scaled) pixel coordinates, line/frame/vblank strobes and a frame counter. It generalises the fixed 320×480-on-12.5875 MHz timing into a mode-configurable block with configurable sync polarity, power-of-two pixel scaling, a clock-enable pause and a frame counter. It sits between the pixel clock and the GPU's fetch/compose pipeline and drives the VGA connector's hsync/vsync.

## Interface
- H_VISIBLE, 320, visible pixel clocks per line
- H_FRONT, 8, horizontal front porch (clocks)
- H_SYNC, 48, hsync width (clocks)
- H_BACK, 24, horizontal back porch (clocks); H_TOTAL = sum = 400
- V_VISIBLE, 480, visible lines; V_FRONT, 10; V_SYNC, 2; V_BACK, 33; V_TOTAL = 525
- HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low; VSYNC_POL, 0, same for vsync
- H_SCALE_LOG2, 0, x = hcount >> H_SCALE_LOG2; V_SCALE_LOG2, 0, same for y
- X_WIDTH, 10; Y_WIDTH, 10; counter widths, must hold H_TOTAL-1 / V_TOTAL-1
- FRAME_WIDTH, 8, frame counter width
- clk_12_5875  input  1  pixel clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable; low freezes all state
- hsync, vsync  output  1  sync pulses, polarity per *_POL
- visible  output  1  pixel in active region
- hcount  output  X_WIDTH  raw horizontal position
- vcount  output  Y_WIDTH  raw line number
- x  output  X_WIDTH  logical x, 0 outside visible
- y  output  Y_WIDTH  logical y, 0 outside visible
- line_start  output  1  one-cycle strobe at hcount==0
- frame_start  output  1  strobe at hcount==0 && vcount==0
- vblank_start  output  1  strobe at hcount==0 && vcount==V_VISIBLE
- frame_count  output  FRAME_WIDTH  completed frames, wraps

## Operation
- Two stages: internal counters (h, v) and one registered output stage holding decode of (h, v); all outputs are registered and mutually aligned.
- Enabled cycle: h increments; h==H_TOTAL-1 → h=0, v increments; v==V_TOTAL-1 with h wrap → v=0, internal frame counter increments (mod 2^FRAME_WIDTH).
- Output stage captures: hcount=h, vcount=v; visible = h<H_VISIBLE && v<V_VISIBLE; hsync active iff H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC; vsync active iff V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC; x/y = shifted counters when visible else 0; strobes per port definitions; frame_count = internal frame counter.
- en=0: counters and output stage hold; line_start, frame_start, vblank_start forced 0 (no repeated strobes while frozen).
- Parameters are static; no runtime mode change.

## Timing
- Reset (async, immediate): h=v=0, frame counter 0; outputs hcount=vcount=x=y=0, visible=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, all strobes 0, frame_count=0.
- First enabled edge after rst falls: outputs describe (0,0): visible=1, line_start=1, frame_start=1, frame_count=0.
- Output latency: one cycle from internal counter to ports.
- Line period H_TOTAL enabled cycles; frame period H_TOTAL×V_TOTAL (210000 default).
- frame_count increments in the same output cycle as frame_start (second frame_start → 1); wraps 2^FRAME_WIDTH-1 → 0.
- rst mid-line: outputs return to reset values asynchronously; resumes at (0,0).
- rst and en=0 together: reset wins.

## Test plan
- Reset release, defaults → first edge: hcount=0, vcount=0, visible=1, line_start=1, frame_start=1, hsync=1, vsync=1, frame_count=0.
- Defaults, one line → hsync low exactly at hcount 328..375 (48 cycles), visible low from hcount 320, line_start every 400 cycles.
- Two full frames → vsync low on vcount 490..491 (800 cycles), vblank_start at vcount 480 hcount 0, frame_count 0→1 at second frame_start 210000 cycles after first.
- H_SCALE_LOG2=1, V_SCALE_LOG2=1 → x holds each value 2 cycles, x=159 at hcount 319, x=0 at hcount 320; y=239 on line 479.
- en low 10 cycles at hcount 100, then at hcount 0 → all outputs frozen, no strobe during freeze, resumes at 101; assert rst mid-line → immediate reset values.
- H 640/16/96/48, V 480/10/2/33, HSYNC_POL=VSYNC_POL=1 → hsync high at hcount 656..751, line period 800, vsync high lines 490..491.
